// File: rtl/object_field_if.sv
// Hook-controller bus of object_field: hook tip and motion flags in,
// caught-object report out.
interface object_field_if #(
  parameter int COORD_W = 11,
  parameter int IDX_W   = 3
);
  logic [COORD_W-1:0] hookX;
  logic [COORD_W-1:0] hookY;
  logic               hookExtending;
  logic               hookReturned;
  logic               grabbed;
  logic [IDX_W-1:0]   grabbedIdx;
  logic [2:0]         grabbedWeight;

  modport master (
    output hookX, hookY, hookExtending, hookReturned,
    input  grabbed, grabbedIdx, grabbedWeight
  );

  modport slave (
    input  hookX, hookY, hookExtending, hookReturned,
    output grabbed, grabbedIdx, grabbedWeight
  );
endinterface

// File: rtl/object_field.sv
// Bank of N_OBJ grabbable objects: grab arbitration, delivery payout, live count
// and registered sprite lookup. Define OBJECT_FIELD_RESPAWN_EN to enable respawn.
module object_field #(
  parameter int N_OBJ          = 8,
  parameter int OBJ_W          = 32,
  parameter int OBJ_H          = 32,
  parameter int COORD_W        = 11,
  parameter int VALUE_W        = 11,
  parameter int RESPAWN_FRAMES = 120,
  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
  localparam int OX_W  = $clog2(OBJ_W),
  localparam int OY_W  = $clog2(OBJ_H)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     manualReset,
  input  logic                     startOfFrame,
  input  logic [N_OBJ*COORD_W-1:0] idleX,
  input  logic [N_OBJ*COORD_W-1:0] idleY,
  input  logic [N_OBJ*4-1:0]       objectType,
  object_field_if.slave            hook,
  input  logic [COORD_W-1:0]       pixelX,
  input  logic [COORD_W-1:0]       pixelY,
  output logic                     payoutValid,
  output logic [VALUE_W-1:0]       payoutValue,
  output logic [4:0]               remaining,
  output logic                     allCleared,
  output logic                     dr,
  output logic [3:0]               spriteType,
  output logic [OX_W-1:0]          spriteOffsetX,
  output logic [OY_W-1:0]          spriteOffsetY
);

  typedef enum logic [1:0] {
    OBJ_IDLE      = 2'd0,
    OBJ_GRABBED   = 2'd1,
    OBJ_DESTROYED = 2'd2
  } obj_state_e;

  localparam logic [COORD_W:0]   SIZE_X = (COORD_W+1)'(OBJ_W);
  localparam logic [COORD_W:0]   SIZE_Y = (COORD_W+1)'(OBJ_H);
  localparam logic [COORD_W-1:0] HALF_X = COORD_W'(OBJ_W / 2);
  localparam logic [COORD_W-1:0] HALF_Y = COORD_W'(OBJ_H / 2);

  function automatic logic is_solid(input logic [3:0] t);
    return (t >= 4'd1) && (t <= 4'd4);
  endfunction

  function automatic logic is_valuable(input logic [3:0] t);
    return (t >= 4'd1) && (t <= 4'd3);
  endfunction

  function automatic logic [2:0] weight_of(input logic [3:0] t);
    case (t)
      4'd1:    weight_of = 3'd1;
      4'd2:    weight_of = 3'd2;
      4'd3:    weight_of = 3'd3;
      4'd4:    weight_of = 3'd4;
      default: weight_of = 3'd0;
    endcase
  endfunction

  function automatic logic [VALUE_W-1:0] value_of(input logic [3:0] t);
    case (t)
      4'd1:    value_of = VALUE_W'(10);
      4'd2:    value_of = VALUE_W'(100);
      4'd3:    value_of = VALUE_W'(1000);
      4'd4:    value_of = VALUE_W'(1);
      default: value_of = '0;
    endcase
  endfunction

  // One extra bit so a box near the right/bottom edge never wraps to 0.
  function automatic logic in_box(input logic [COORD_W-1:0] tl,
                                  input logic [COORD_W-1:0] p,
                                  input logic [COORD_W:0]   size);
    logic [COORD_W:0] lo;
    lo = {1'b0, tl};
    return ({1'b0, p} >= lo) && ({1'b0, p} < lo + size);
  endfunction

  obj_state_e           state_q [N_OBJ];
  obj_state_e           state_d [N_OBJ];
  logic                 grabbed_q, grabbed_d;
  logic [IDX_W-1:0]     grabbed_idx_q, grabbed_idx_d;
  logic [3:0]           grabbed_type_q, grabbed_type_d;
  logic [2:0]           grabbed_weight_q, grabbed_weight_d;
  logic                 payout_valid_q, payout_valid_d;
  logic [VALUE_W-1:0]   payout_value_q, payout_value_d;
  logic [4:0]           remaining_q, remaining_d;
  logic                 all_cleared_q, all_cleared_d;
  logic                 dr_q, dr_d;
  logic [3:0]           sprite_type_q, sprite_type_d;
  logic [OX_W-1:0]      sprite_off_x_q, sprite_off_x_d;
  logic [OY_W-1:0]      sprite_off_y_q, sprite_off_y_d;

  logic                 grab_hit_s;
  logic [IDX_W-1:0]     grab_idx_s;
  logic [3:0]           grab_type_s;
  logic                 deliver_s;
  logic                 take_s;
  logic [COORD_W-1:0]   grab_x_s, grab_y_s;
  logic                 hit_s;
  logic [3:0]           hit_type_s;
  logic [COORD_W-1:0]   hit_x_s, hit_y_s;
  logic [4:0]           live_cnt_s;

`ifdef OBJECT_FIELD_RESPAWN_EN
  logic [7:0]           frame_cnt_q [N_OBJ];
  logic [7:0]           frame_cnt_d [N_OBJ];
`else
  logic                 unused_s;
  assign unused_s = startOfFrame | (RESPAWN_FRAMES == 0);
`endif

  // Held object is centred on the hook tip, clamped at the screen origin.
  assign grab_x_s  = (hook.hookX < HALF_X) ? '0 : hook.hookX - HALF_X;
  assign grab_y_s  = (hook.hookY < HALF_Y) ? '0 : hook.hookY - HALF_Y;
  assign deliver_s = grabbed_q & hook.hookReturned;
  assign take_s    = ~grabbed_q & hook.hookExtending & grab_hit_s;

  // Lowest-index idle solid object under the hook tip.
  always_comb begin
    grab_hit_s  = 1'b0;
    grab_idx_s  = '0;
    grab_type_s = 4'd0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (!grab_hit_s && (state_q[i] == OBJ_IDLE) && is_solid(objectType[i*4 +: 4]) &&
          in_box(idleX[i*COORD_W +: COORD_W], hook.hookX, SIZE_X) &&
          in_box(idleY[i*COORD_W +: COORD_W], hook.hookY, SIZE_Y)) begin
        grab_hit_s  = 1'b1;
        grab_idx_s  = IDX_W'(i);
        grab_type_s = objectType[i*4 +: 4];
      end else begin
        grab_hit_s  = grab_hit_s;
      end
    end
  end

  // Object state, held-object latch and payout.
  always_comb begin
    state_d          = state_q;
    grabbed_d        = grabbed_q;
    grabbed_idx_d    = grabbed_idx_q;
    grabbed_type_d   = grabbed_type_q;
    grabbed_weight_d = grabbed_weight_q;
    payout_valid_d   = 1'b0;
    payout_value_d   = '0;
    if (manualReset) begin
      for (int i = 0; i < N_OBJ; i++) begin
        state_d[i] = OBJ_IDLE;
      end
      grabbed_d        = 1'b0;
      grabbed_idx_d    = '0;
      grabbed_type_d   = 4'd0;
      grabbed_weight_d = 3'd0;
    end else if (deliver_s) begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (grabbed_idx_q == IDX_W'(i)) begin
          state_d[i] = OBJ_DESTROYED;
        end else begin
          state_d[i] = state_q[i];
        end
      end
      grabbed_d        = 1'b0;
      grabbed_idx_d    = '0;
      grabbed_type_d   = 4'd0;
      grabbed_weight_d = 3'd0;
      payout_valid_d   = 1'b1;
      payout_value_d   = value_of(grabbed_type_q);
    end else if (take_s) begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (grab_idx_s == IDX_W'(i)) begin
          state_d[i] = OBJ_GRABBED;
        end else begin
          state_d[i] = state_q[i];
        end
      end
      grabbed_d        = 1'b1;
      grabbed_idx_d    = grab_idx_s;
      grabbed_type_d   = grab_type_s;
      grabbed_weight_d = weight_of(grab_type_s);
    end else begin
      grabbed_d        = grabbed_q;
    end
`ifdef OBJECT_FIELD_RESPAWN_EN
    for (int i = 0; i < N_OBJ; i++) begin
      if (manualReset) begin
        frame_cnt_d[i] = 8'd0;
      end else if ((state_q[i] == OBJ_DESTROYED) && startOfFrame) begin
        if (frame_cnt_q[i] + 8'd1 == 8'(RESPAWN_FRAMES)) begin
          state_d[i]     = OBJ_IDLE;
          frame_cnt_d[i] = 8'd0;
        end else begin
          frame_cnt_d[i] = frame_cnt_q[i] + 8'd1;
        end
      end else begin
        frame_cnt_d[i] = frame_cnt_q[i];
      end
    end
`endif
  end

  // Pixel hit: held object first, then the lowest-index idle solid object.
  always_comb begin
    hit_s      = 1'b0;
    hit_type_s = 4'd0;
    hit_x_s    = '0;
    hit_y_s    = '0;
    if (grabbed_q && in_box(grab_x_s, pixelX, SIZE_X) && in_box(grab_y_s, pixelY, SIZE_Y)) begin
      hit_s      = 1'b1;
      hit_type_s = grabbed_type_q;
      hit_x_s    = grab_x_s;
      hit_y_s    = grab_y_s;
    end else begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (!hit_s && (state_q[i] == OBJ_IDLE) && is_solid(objectType[i*4 +: 4]) &&
            in_box(idleX[i*COORD_W +: COORD_W], pixelX, SIZE_X) &&
            in_box(idleY[i*COORD_W +: COORD_W], pixelY, SIZE_Y)) begin
          hit_s      = 1'b1;
          hit_type_s = objectType[i*4 +: 4];
          hit_x_s    = idleX[i*COORD_W +: COORD_W];
          hit_y_s    = idleY[i*COORD_W +: COORD_W];
        end else begin
          hit_s      = hit_s;
        end
      end
    end
    if (manualReset || !hit_s) begin
      dr_d           = 1'b0;
      sprite_type_d  = 4'd0;
      sprite_off_x_d = '0;
      sprite_off_y_d = '0;
    end else begin
      dr_d           = 1'b1;
      sprite_type_d  = hit_type_s;
      sprite_off_x_d = OX_W'(pixelX - hit_x_s);
      sprite_off_y_d = OY_W'(pixelY - hit_y_s);
    end
  end

  // Live valuables; deliberately taken from the registered state.
  always_comb begin
    live_cnt_s = 5'd0;
    for (int i = 0; i < N_OBJ; i++) begin
      if ((state_q[i] != OBJ_DESTROYED) && is_valuable(objectType[i*4 +: 4])) begin
        live_cnt_s = live_cnt_s + 5'd1;
      end else begin
        live_cnt_s = live_cnt_s;
      end
    end
    if (manualReset) begin
      remaining_d   = 5'd0;
      all_cleared_d = 1'b1;
    end else begin
      remaining_d   = live_cnt_s;
      all_cleared_d = (live_cnt_s == 5'd0);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OBJ; i++) begin
        state_q[i] <= OBJ_IDLE;
      end
      grabbed_q        <= 1'b0;
      grabbed_idx_q    <= '0;
      grabbed_type_q   <= 4'd0;
      grabbed_weight_q <= 3'd0;
      payout_valid_q   <= 1'b0;
      payout_value_q   <= '0;
      remaining_q      <= 5'd0;
      all_cleared_q    <= 1'b1;
      dr_q             <= 1'b0;
      sprite_type_q    <= 4'd0;
      sprite_off_x_q   <= '0;
      sprite_off_y_q   <= '0;
    end else begin
      state_q          <= state_d;
      grabbed_q        <= grabbed_d;
      grabbed_idx_q    <= grabbed_idx_d;
      grabbed_type_q   <= grabbed_type_d;
      grabbed_weight_q <= grabbed_weight_d;
      payout_valid_q   <= payout_valid_d;
      payout_value_q   <= payout_value_d;
      remaining_q      <= remaining_d;
      all_cleared_q    <= all_cleared_d;
      dr_q             <= dr_d;
      sprite_type_q    <= sprite_type_d;
      sprite_off_x_q   <= sprite_off_x_d;
      sprite_off_y_q   <= sprite_off_y_d;
    end
  end

`ifdef OBJECT_FIELD_RESPAWN_EN
  // Per-object frame counters while destroyed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OBJ; i++) begin
        frame_cnt_q[i] <= 8'd0;
      end
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`endif

  assign hook.grabbed       = grabbed_q;
  assign hook.grabbedIdx    = grabbed_idx_q;
  assign hook.grabbedWeight = grabbed_weight_q;
  assign payoutValid        = payout_valid_q;
  assign payoutValue        = payout_value_q;
  assign remaining          = remaining_q;
  assign allCleared         = all_cleared_q;
  assign dr                 = dr_q;
  assign spriteType         = sprite_type_q;
  assign spriteOffsetX      = sprite_off_x_q;
  assign spriteOffsetY      = sprite_off_y_q;

endmodule

// File: tb/tb_object_field.sv
// Self-checking bench for object_field: directed scenarios plus a randomized run
// against a behavioural model of the object field.
module tb_object_field;
  localparam int N  = 8;
  localparam int CW = 11;
  localparam int VW = 11;
  localparam int IW = 3;
  localparam int RF = 3;
`ifdef OBJECT_FIELD_RESPAWN_EN
  localparam int RESP_EN = 1;
`else
  localparam int RESP_EN = 0;
`endif

  logic            clk = 1'b0;
  logic            reset, manualReset, startOfFrame;
  logic [N*CW-1:0] idleX, idleY;
  logic [N*4-1:0]  objectType;
  logic [CW-1:0]   pixelX, pixelY;
  logic            payoutValid, allCleared, dr;
  logic [VW-1:0]   payoutValue;
  logic [4:0]      remaining;
  logic [3:0]      spriteType;
  logic [4:0]      spriteOffsetX, spriteOffsetY;

  object_field_if #(.COORD_W(CW), .IDX_W(IW)) hook_if ();

  object_field #(.N_OBJ(N), .RESPAWN_FRAMES(RF)) dut (
    .clk(clk), .reset(reset), .manualReset(manualReset), .startOfFrame(startOfFrame),
    .idleX(idleX), .idleY(idleY), .objectType(objectType), .hook(hook_if),
    .pixelX(pixelX), .pixelY(pixelY), .payoutValid(payoutValid), .payoutValue(payoutValue),
    .remaining(remaining), .allCleared(allCleared), .dr(dr), .spriteType(spriteType),
    .spriteOffsetX(spriteOffsetX), .spriteOffsetY(spriteOffsetY)
  );

  always #5 clk = ~clk;

  int n_chk, n_pass;
  // model: layout, per-object status (0 idle, 1 held, 2 gone), frames gone
  int ix [N], iy [N], ot [N], st [N], fr [N];
  int hold, hidx, htype;
  int e_pv, e_pval, e_dr, e_st, e_ox, e_oy, e_rem;

  function automatic int solid(int t); return (t >= 1 && t <= 4); endfunction
  function automatic int valuable(int t); return (t >= 1 && t <= 3); endfunction
  function automatic int wt(int t); return solid(t) ? t : 0; endfunction
  function automatic int val(int t);
    return (t == 1) ? 10 : (t == 2) ? 100 : (t == 3) ? 1000 : (t == 4) ? 1 : 0;
  endfunction
  function automatic int inb(int lo, int p); return (p >= lo && p < lo + 32); endfunction
  function automatic int clampc(int v); return (v > 2047) ? 2047 : v; endfunction

  function automatic logic [39:0] exp_vec();
    return {1'(hold), 3'(hidx), 3'(wt(htype)), 1'(e_pv), 11'(e_pval), 5'(e_rem),
            1'(e_rem == 0), 1'(e_dr), 4'(e_st), 5'(e_ox), 5'(e_oy)};
  endfunction

  function automatic logic [39:0] got_vec();
    return {hook_if.grabbed, hook_if.grabbedIdx, hook_if.grabbedWeight, payoutValid, payoutValue,
            remaining, allCleared, dr, spriteType, spriteOffsetX, spriteOffsetY};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin st[i] = 0; fr[i] = 0; end
    hold = 0; hidx = 0; htype = 0;
    e_pv = 0; e_pval = 0; e_dr = 0; e_st = 0; e_ox = 0; e_oy = 0; e_rem = 0;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      idleX[i*CW +: CW] = CW'(ix[i]);
      idleY[i*CW +: CW] = CW'(iy[i]);
      objectType[i*4 +: 4] = 4'(ot[i]);
    end
  endtask

  task automatic set_hook(int x, int y, int ext, int ret);
    hook_if.hookX = CW'(x); hook_if.hookY = CW'(y);
    hook_if.hookExtending = 1'(ext); hook_if.hookReturned = 1'(ret);
  endtask

  task automatic set_pix(int x, int y);
    pixelX = CW'(x); pixelY = CW'(y);
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic step();
    int pst [N];
    int hx, hy, px, py, gx, gy, rdr, rt, rox, roy, nr, gi;
    pst = st;
    hx = int'(hook_if.hookX); hy = int'(hook_if.hookY);
    px = int'(pixelX);        py = int'(pixelY);
    gx = (hx >= 16) ? hx - 16 : 0;
    gy = (hy >= 16) ? hy - 16 : 0;
    rdr = 0; rt = 0; rox = 0; roy = 0;
    if (hold != 0 && inb(gx, px) != 0 && inb(gy, py) != 0) begin
      rdr = 1; rt = htype; rox = px - gx; roy = py - gy;
    end else begin
      for (int i = 0; i < N; i++)
        if (rdr == 0 && pst[i] == 0 && solid(ot[i]) != 0 && inb(ix[i], px) != 0 && inb(iy[i], py) != 0) begin
          rdr = 1; rt = ot[i]; rox = px - ix[i]; roy = py - iy[i];
        end
    end
    nr = 0;
    for (int i = 0; i < N; i++) if (pst[i] != 2 && valuable(ot[i]) != 0) nr++;
    if (manualReset) begin
      model_reset();
    end else begin
      e_dr = rdr; e_st = rt; e_ox = rox; e_oy = roy; e_rem = nr; e_pv = 0; e_pval = 0;
      if (hold != 0 && hook_if.hookReturned) begin
        st[hidx] = 2; fr[hidx] = 0; e_pv = 1; e_pval = val(htype);
        hold = 0; hidx = 0; htype = 0;
      end else if (hold == 0 && hook_if.hookExtending) begin
        gi = -1;
        for (int i = 0; i < N; i++)
          if (gi < 0 && pst[i] == 0 && solid(ot[i]) != 0 && inb(ix[i], hx) != 0 && inb(iy[i], hy) != 0) gi = i;
        if (gi >= 0) begin st[gi] = 1; hold = 1; hidx = gi; htype = ot[gi]; end
      end
      if (RESP_EN != 0 && startOfFrame)
        for (int i = 0; i < N; i++)
          if (pst[i] == 2) begin
            fr[i]++;
            if (fr[i] >= RF) begin st[i] = 0; fr[i] = 0; end
          end
    end
    @(posedge clk); #1;
  endtask

  task automatic layout();
    ix = '{100, 300, 500, 700, 900, 510, 1000, 2040};
    iy = '{100, 100, 300, 300, 100, 310, 500, 50};
    ot = '{3, 1, 2, 4, 0, 1, 9, 2};
    pack();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    set_hook(105, 105, 1, 0); set_pix(105, 105);
    step();
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL pre_reset got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
    set_hook(105, 105, 0, 0);
    step();
    #2 reset = 1'b1;
    #1 model_reset();
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL async_reset got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
    n_chk++; if ({hook_if.grabbed, dr, payoutValid} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {hook_if.grabbed, dr, payoutValid}); else n_pass++;
    reset = 1'b0;
    step();
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL post_reset got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
    n_chk++; if (remaining !== 5'd5) $display("FAIL reset_remaining got=%0d exp=5", remaining); else n_pass++;
  endtask

  task automatic test_grab_deliver();
    set_hook(105, 105, 1, 0);
    step();
    n_chk++; if ({hook_if.grabbed, hook_if.grabbedIdx, hook_if.grabbedWeight} !== {1'b1, 3'd0, 3'd3})
      $display("FAIL grab0 got=%b/%0d/%0d exp=1/0/3", hook_if.grabbed, hook_if.grabbedIdx, hook_if.grabbedWeight); else n_pass++;
    set_hook(105, 105, 0, 1);
    step();
    n_chk++; if ({payoutValid, payoutValue} !== {1'b1, 11'd1000}) $display("FAIL payout1000 got=%b/%0d exp=1/1000", payoutValid, payoutValue); else n_pass++;
    n_chk++; if (remaining !== 5'd5) $display("FAIL remaining_lag got=%0d exp=5", remaining); else n_pass++;
    set_hook(105, 105, 0, 0);
    step();
    n_chk++; if ({payoutValid, remaining} !== {1'b0, 5'd4}) $display("FAIL after_delivery got=%b/%0d exp=0/4", payoutValid, remaining); else n_pass++;
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL deliver_vec got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
  endtask

  task automatic test_overlap();
    set_hook(515, 315, 1, 0);
    step();
    n_chk++; if ({hook_if.grabbedIdx, hook_if.grabbedWeight} !== {3'd2, 3'd2}) $display("FAIL overlap_idx got=%0d/%0d exp=2/2", hook_if.grabbedIdx, hook_if.grabbedWeight); else n_pass++;
    set_hook(535, 335, 1, 0); set_pix(525, 325);
    repeat (2) step();
    n_chk++; if (hook_if.grabbedIdx !== 3'd2) $display("FAIL no_regrab got=%0d exp=2", hook_if.grabbedIdx); else n_pass++;
    n_chk++; if ({dr, spriteType, spriteOffsetX, spriteOffsetY} !== {1'b1, 4'd2, 5'd6, 5'd6})
      $display("FAIL render_priority got=%b/%0d/%0d/%0d exp=1/2/6/6", dr, spriteType, spriteOffsetX, spriteOffsetY); else n_pass++;
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL overlap_vec got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
    set_hook(535, 335, 0, 1);
    step();
    n_chk++; if (payoutValue !== 11'd100) $display("FAIL payout100 got=%0d exp=100", payoutValue); else n_pass++;
    set_hook(535, 335, 0, 0);
    step();
  endtask

  task automatic test_edges();
    set_pix(5, 60);
    step();
    n_chk++; if (dr !== 1'b0) $display("FAIL no_wrap got=%b exp=0", dr); else n_pass++;
    set_pix(2045, 60);
    step();
    n_chk++; if ({dr, spriteType, spriteOffsetX, spriteOffsetY} !== {1'b1, 4'd2, 5'd5, 5'd10})
      $display("FAIL edge_draw got=%b/%0d/%0d/%0d exp=1/2/5/10", dr, spriteType, spriteOffsetX, spriteOffsetY); else n_pass++;
    set_hook(905, 105, 1, 0); set_pix(905, 105);
    step();
    n_chk++; if ({hook_if.grabbed, dr} !== 2'b00) $display("FAIL filler0 got=%b exp=00", {hook_if.grabbed, dr}); else n_pass++;
    set_hook(1005, 505, 1, 0); set_pix(1005, 505);
    step();
    n_chk++; if ({hook_if.grabbed, dr} !== 2'b00) $display("FAIL filler9 got=%b exp=00", {hook_if.grabbed, dr}); else n_pass++;
    ix[1] = 0; iy[1] = 0; pack();
    set_hook(3, 3, 1, 0); set_pix(0, 0);
    step();
    n_chk++; if (hook_if.grabbedIdx !== 3'd1) $display("FAIL corner_grab got=%0d exp=1", hook_if.grabbedIdx); else n_pass++;
    set_hook(3, 3, 0, 0); set_pix(31, 31);
    repeat (2) step();
    n_chk++; if ({dr, spriteOffsetX, spriteOffsetY} !== {1'b1, 5'd31, 5'd31}) $display("FAIL saturate got=%b/%0d/%0d exp=1/31/31", dr, spriteOffsetX, spriteOffsetY); else n_pass++;
    set_hook(3, 3, 0, 1);
    step();
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL corner_deliver got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
    set_hook(3, 3, 0, 0);
    step();
  endtask

  task automatic test_respawn();
    set_pix(5, 5);
    for (int f = 0; f < 10; f++) begin
      startOfFrame = 1'b1; step();
      startOfFrame = 1'b0; step();
    end
    n_chk++; if (dr !== 1'(RESP_EN)) $display("FAIL respawn_draw got=%b exp=%0d", dr, RESP_EN); else n_pass++;
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL respawn_vec got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
  endtask

  task automatic test_weight_latch();
    set_hook(705, 305, 1, 0);
    step();
    ot[3] = 1; pack();
    set_hook(705, 305, 0, 0);
    step();
    n_chk++; if (hook_if.grabbedWeight !== 3'd4) $display("FAIL weight_latch got=%0d exp=4", hook_if.grabbedWeight); else n_pass++;
    set_hook(705, 305, 0, 1);
    step();
    n_chk++; if ({payoutValid, payoutValue} !== {1'b1, 11'd1}) $display("FAIL payout_rock got=%b/%0d exp=1/1", payoutValid, payoutValue); else n_pass++;
    ot[3] = 4; pack();
    set_hook(705, 305, 0, 0);
    step();
  endtask

  task automatic test_manual_reset();
    manualReset = 1'b1; set_hook(515, 315, 1, 1);
    step();
    n_chk++; if (got_vec() !== exp_vec()) $display("FAIL manual_reset got=%h exp=%h", got_vec(), exp_vec()); else n_pass++;
    manualReset = 1'b0; set_hook(515, 315, 0, 0);
    step();
    n_chk++; if (remaining !== 5'd5) $display("FAIL manual_remaining got=%0d exp=5", remaining); else n_pass++;
  endtask

  task automatic test_random();
    int k, hx;
    for (int c = 0; c < 800; c++) begin
      if (c % 200 == 0) begin
        for (int i = 0; i < N; i++) begin
          ix[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1990, 2047)) : int'($urandom_range(0, 200));
          iy[i] = int'($urandom_range(0, 200));
          ot[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 15));
        end
        pack();
      end
      k = int'($urandom_range(0, N - 1));
      hx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : clampc(ix[k] + int'($urandom_range(0, 40)));
      set_hook(hx, clampc(iy[k] + int'($urandom_range(0, 40))), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 5) == 0));
      k = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 0)
        set_pix(clampc(ix[k] + int'($urandom_range(0, 35))), clampc(iy[k] + int'($urandom_range(0, 35))));
      else
        set_pix(clampc(((hx >= 16) ? hx - 16 : 0) + int'($urandom_range(0, 35))), int'($urandom_range(0, 240)));
      startOfFrame = 1'($urandom_range(0, 3) == 0);
      manualReset  = 1'($urandom_range(0, 99) == 0);
      step();
      n_chk++; if (got_vec() !== exp_vec()) $display("FAIL random c=%0d got=%h exp=%h", c, got_vec(), exp_vec()); else n_pass++;
    end
    manualReset = 1'b0; startOfFrame = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b1; manualReset = 1'b0; startOfFrame = 1'b0;
    set_hook(0, 0, 0, 0); set_pix(0, 0);
    layout();
    test_reset();
    test_grab_deliver();
    test_overlap();
    test_edges();
    test_respawn();
    test_weight_latch();
    test_manual_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
